// File: rtl/integration_pkg.sv
// Shared constants and FSM state type for the AHB bus arbiter.
package integration_pkg;

  localparam int MASTER_NUMBER  = 4;
  localparam int DEFAULT_MASTER = MASTER_NUMBER - 1;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    LOCKED    = 2'd1,
    LOCK_TAIL = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ahb_priority_encoder.sv
// Fixed-priority select: lowest set index wins, else the top master.
module ahb_priority_encoder
  import integration_pkg::*;
#(
  parameter int master_number = MASTER_NUMBER
) (
  input  logic [master_number-1:0] i_req,
  output logic [master_number-1:0] o_grant,
  output logic [3:0]               o_index
);

  logic       w_found;
  logic [3:0] w_index;

  always_comb begin
    w_found = 1'b0;
    w_index = 4'(master_number - 1);
    for (int i = 0; i < master_number; i++) begin
      if (!w_found && i_req[i]) begin
        w_found = 1'b1;
        w_index = 4'(i);
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int i = 0; i < master_number; i++) begin
      if (w_index == 4'(i)) o_grant[i] = 1'b1;
    end
  end

  assign o_index = w_index;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Fixed-priority AHB arbiter with locked-transfer hold and one-beat tail.
module ahb_bus_arbiter
  import integration_pkg::*;
#(
  parameter int master_number = MASTER_NUMBER
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [master_number-1:0] hbusreq,
  input  logic [master_number-1:0] hlock,
  input  logic                     hready,
  output logic [master_number-1:0] hgrant,
  output logic [3:0]               hmaster,
  output logic                     hmastlock
);

  localparam logic [3:0] DEF_IDX = 4'(master_number - 1);

  arb_state_t               r_state;
  logic [master_number-1:0] r_hgrant;
  logic [3:0]               r_hmaster;
  logic                     r_hmastlock;

  logic [master_number-1:0] w_pe_grant;
  logic [3:0]               w_pe_index;
  logic [3:0]               w_gidx;
  logic                     w_greq;
  logic                     w_glock;

  ahb_priority_encoder #(
    .master_number(master_number)
  ) u_pe (
    .i_req  (hbusreq),
    .o_grant(w_pe_grant),
    .o_index(w_pe_index)
  );

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < master_number; i++) begin
      if (r_hgrant[i]) w_gidx = w_gidx | 4'(i);
    end
  end

  assign w_greq  = |(r_hgrant & hbusreq);
  assign w_glock = |(r_hgrant & hlock);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state     <= ARB;
      r_hgrant    <= '0;
      r_hgrant[master_number-1] <= 1'b1;
      r_hmaster   <= DEF_IDX;
      r_hmastlock <= 1'b0;
    end else if (hready) begin
      r_hmaster   <= w_gidx;
      r_hmastlock <= w_glock;
      case (r_state)
        ARB: begin
          if (w_greq && w_glock) r_state  <= LOCKED;
          else                   r_hgrant <= w_pe_grant;
        end
        LOCKED: begin
          if (!(w_greq && w_glock)) r_state <= LOCK_TAIL;
        end
        LOCK_TAIL: r_state <= ARB;
        default:   r_state <= ARB;
      endcase
    end
  end

  assign hgrant    = r_hgrant;
  assign hmaster   = r_hmaster;
  assign hmastlock = r_hmastlock;

  logic w_unused;
  assign w_unused = ^w_pe_index;

endmodule

// File: doc/ahb_bus_arbiter.md
AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Interface
REQ-001 The block SHALL have one parameter per line: master_number, default 4, number of bus masters, legal range 2..16.
REQ-002 hclk  in  1  the only clock; all state updates on its rising edge.
REQ-003 hreset  in  1  reset; synchronous, active-high.
REQ-004 hbusreq  in  master_number  per-master bus request.
REQ-005 hlock  in  master_number  per-master locked-transfer request.
REQ-006 hready  in  1  slave transfer-done indication; gates all handover.
REQ-007 hgrant  out  master_number  one-hot grant, registered.
REQ-008 hmaster  out  4  index of the master owning the address phase, registered, zero-extended.
REQ-009 hmastlock  out  1  current owner performing a locked transfer, registered.

Function
REQ-010 Priority SHALL be fixed: lower index wins; master_number-1 is lowest priority and the default master.
REQ-011 hgrant SHALL be exactly one-hot on every cycle after reset; never all-zero, never multi-hot.
REQ-012 The FSM SHALL have states ARB, LOCKED and LOCK_TAIL; g = index of the current hgrant.
REQ-013 ARB, hready=1 edge, hbusreq[g]=1 and hlock[g]=1: hgrant SHALL hold, next state LOCKED.
REQ-014 ARB, hready=1 edge, otherwise: hgrant SHALL load the one-hot of the highest-priority set bit of hbusreq, or of master_number-1 if hbusreq is all-zero; state stays ARB.
REQ-015 LOCKED, hready=1 edge: hgrant SHALL hold; if hlock[g]=0 or hbusreq[g]=0, next state LOCK_TAIL, else stay LOCKED.
REQ-016 LOCK_TAIL, hready=1 edge: hgrant SHALL hold for this one extra transfer; next state ARB.
REQ-017 Any edge with hready=0: hgrant, hmaster, hmastlock and state SHALL hold unchanged.
REQ-018 hready=1 edge: hmaster SHALL load g from the pre-edge hgrant, so hmaster lags hgrant by exactly one hready=1 edge.
REQ-019 hready=1 edge: hmastlock SHALL load hlock[g] from the pre-edge value.
REQ-020 hlock[i] with hbusreq[i]=0 SHALL have no effect on arbitration.
REQ-021 Requests from other masters during LOCKED or LOCK_TAIL SHALL be ignored; they are not queued and are re-evaluated in ARB.
REQ-022 Grant latency from request to hgrant SHALL be one hready=1 edge in ARB; there is no combinational input-to-output path.

Reset
REQ-023 hreset=1 at an edge SHALL force: hgrant = one-hot bit master_number-1, hmaster = master_number-1, hmastlock = 0, state = ARB.
REQ-024 Reset SHALL override all inputs, including hready=0 and an active lock.
REQ-025 The first edge with hreset=0 SHALL arbitrate normally.

Structure
REQ-026 integration_pkg SHALL hold the master_number constant, the arb_state_t enum (ARB, LOCKED, LOCK_TAIL) and the DEFAULT_MASTER constant (master_number-1).
REQ-027 Fixed-priority selection SHALL be one sub-module, ahb_priority_encoder.
REQ-028 ahb_priority_encoder: input request vector; outputs a one-hot grant and a 4-bit index; returns the default master when no request is set.
REQ-029 The FSM, grant register, hmaster register and hmastlock register SHALL reside in ahb_bus_arbiter.

Verification (master_number=4)
REQ-030 Reset with no requests -> after reset release: hgrant=4'b1000, hmaster=3, hmastlock=0.
REQ-031 hbusreq=4'b0110 with hready=1 -> next edge: hgrant=4'b0010; following edge: hmaster=1.
REQ-032 hbusreq=4'b0001 with hready=0 for 3 cycles -> outputs unchanged during those cycles; hready=1 -> hgrant=4'b0001 on that edge, hmaster=0 one hready edge later.
REQ-033 Master 2 granted with hbusreq[2]=hlock[2]=1, master 0 also requesting -> hgrant stays 4'b0100 and hmastlock=1; hlock[2] drops -> one more hready edge held (LOCK_TAIL), then hgrant=4'b0001.
REQ-034 hreset pulsed while in LOCKED with hready=0 -> next edge: hgrant=4'b1000, hmaster=3, hmastlock=0, state ARB.
REQ-035 The bench SHALL assert on every cycle after reset: $onehot(hgrant), and hgrant&hready followed one edge later by hmaster equal to the granted index.
